// File: rtl/mcu_component_sequencer.sv
// JPEG MCU component sequencer: interleaves Y, Cb and Cr block streams in MCU
// order, steering the 3:1 component mux and the valid/ready handshake.
module mcu_component_sequencer #(
  parameter int BLOCK_LEN = 64,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       y_blocks,
  input  logic             chroma_en,
  input  logic [CNT_W-1:0] num_mcu,
  input  logic             x0_valid,
  input  logic             x1_valid,
  input  logic             x2_valid,
  output logic             x0_ready,
  output logic             x1_ready,
  output logic             x2_ready,
  output logic [1:0]       code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             block_last,
  output logic             mcu_last,
  output logic             busy,
  output logic             frame_done
);

  localparam int BW = $clog2(BLOCK_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_Y,
    S_SEND_CB,
    S_SEND_CR,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [1:0]       r_code;
  logic [1:0]       w_next_code;
  logic [BW-1:0]    r_byte_cnt;
  logic [1:0]       r_blk_cnt;
  logic [CNT_W-1:0] r_mcu_cnt;
  logic [1:0]       r_yb_m1;
  logic             r_chroma;
  logic [CNT_W-1:0] r_num_mcu;

  logic             w_send;
  logic             w_sel_valid;
  logic             w_xfer;
  logic             w_block_last;
  logic             w_last_y;
  logic             w_mcu_last;
  logic             w_blk_done;
  logic             w_mcu_end;
  logic             w_frame_end;
  logic [CNT_W-1:0] w_mcu_inc;
  logic [1:0]       w_yb_m1;

  // Y block count is stored minus one so 0 maps to a single block and >4 to four.
  always_comb begin
    w_yb_m1 = 2'd0;
    case (y_blocks)
      3'd0, 3'd1: w_yb_m1 = 2'd0;
      3'd2:       w_yb_m1 = 2'd1;
      3'd3:       w_yb_m1 = 2'd2;
      default:    w_yb_m1 = 2'd3;
    endcase
  end

  always_comb begin
    w_send      = 1'b0;
    w_sel_valid = 1'b0;
    x0_ready    = 1'b0;
    x1_ready    = 1'b0;
    x2_ready    = 1'b0;
    case (r_state)
      S_SEND_Y: begin
        w_send      = 1'b1;
        w_sel_valid = x0_valid;
        x0_ready    = out_ready;
      end
      S_SEND_CB: begin
        w_send      = 1'b1;
        w_sel_valid = x1_valid;
        x1_ready    = out_ready;
      end
      S_SEND_CR: begin
        w_send      = 1'b1;
        w_sel_valid = x2_valid;
        x2_ready    = out_ready;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_xfer       = w_sel_valid & out_ready;
    w_block_last = w_send & (r_byte_cnt == BW'(BLOCK_LEN - 1));
    w_last_y     = (r_blk_cnt == r_yb_m1);
    w_mcu_last   = w_block_last &
                   ((r_state == S_SEND_CR) ||
                    ((r_state == S_SEND_Y) && w_last_y && !r_chroma));
    w_blk_done   = w_xfer & w_block_last;
    w_mcu_end    = w_xfer & w_mcu_last;
    w_mcu_inc    = r_mcu_cnt + CNT_W'(1);
    w_frame_end  = (w_mcu_inc == r_num_mcu);
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = (num_mcu == '0) ? S_DONE : S_SEND_Y;
        end
      end
      S_SEND_Y: begin
        if (w_blk_done) begin
          if (!w_last_y) begin
            w_next_state = S_SEND_Y;
          end else if (r_chroma) begin
            w_next_state = S_SEND_CB;
          end else begin
            w_next_state = w_frame_end ? S_DONE : S_SEND_Y;
          end
        end
      end
      S_SEND_CB: begin
        if (w_blk_done) begin
          w_next_state = S_SEND_CR;
        end
      end
      S_SEND_CR: begin
        if (w_blk_done) begin
          w_next_state = w_frame_end ? S_DONE : S_SEND_Y;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // code is registered from the next state so it switches on the same edge as the state.
  always_comb begin
    w_next_code = 2'b11;
    case (w_next_state)
      S_SEND_Y:  w_next_code = 2'b00;
      S_SEND_CB: w_next_code = 2'b01;
      S_SEND_CR: w_next_code = 2'b10;
      default:   w_next_code = 2'b11;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_code  <= 2'b11;
    end else begin
      r_state <= w_next_state;
      r_code  <= w_next_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt <= '0;
      r_blk_cnt  <= '0;
      r_mcu_cnt  <= '0;
      r_yb_m1    <= '0;
      r_chroma   <= 1'b0;
      r_num_mcu  <= '0;
    end else if (r_state == S_IDLE) begin
      r_byte_cnt <= '0;
      r_blk_cnt  <= '0;
      r_mcu_cnt  <= '0;
      if (start) begin
        r_yb_m1   <= w_yb_m1;
        r_chroma  <= chroma_en;
        r_num_mcu <= num_mcu;
      end
    end else if (w_xfer) begin
      r_byte_cnt <= w_block_last ? '0 : r_byte_cnt + BW'(1);
      if (w_blk_done) begin
        if ((r_state == S_SEND_Y) && !w_last_y) begin
          r_blk_cnt <= r_blk_cnt + 2'd1;
        end else begin
          r_blk_cnt <= '0;
        end
      end
      if (w_mcu_end) begin
        r_mcu_cnt <= w_mcu_inc;
      end
    end
  end

  always_comb begin
    code       = r_code;
    out_valid  = w_sel_valid;
    block_last = w_block_last;
    mcu_last   = w_mcu_last;
    busy       = w_send;
    frame_done = (r_state == S_DONE);
  end

endmodule
